// File: rtl/taxi_axis_if.sv
// AXI-Stream bundle shared by the AES pipeline stages.
//   src : driven by the producer (tdata/tkeep/tstrb/tvalid/tlast/tid/tdest/tuser), receives tready
//   snk : driven by the consumer (tready), receives everything else
interface taxi_axis_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = (DATA_W + 7) / 8,
  parameter int ID_W   = 8,
  parameter int DEST_W = 8,
  parameter int USER_W = 1
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, input tready);
  modport snk (input tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/aes_block_serializer.sv
// Serialises 128-bit plaintext blocks from the AES inverse cipher into a byte
// stream, most significant byte first, through a small block FIFO. Blocks
// flagged as the last of a message can have PKCS#7 padding stripped.
//   Clk, Rst  : clock, synchronous active-high reset
//   En        : enable; low clears the block exactly like Rst
//   PadStrip  : strip padding from blocks with tuser[0]=1 (sampled at accept)
//   PadErr    : one-cycle pulse after accepting a strip-eligible block with bad padding
//   s_axis    : 128-bit block sink (tuser[0] = last block of message)
//   m_axis    : 8-bit byte source toward the UART path
module aes_block_serializer #(
  parameter int DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        En,
  input  logic        PadStrip,
  output logic        PadErr,
  taxi_axis_if.snk    s_axis,
  taxi_axis_if.src    m_axis
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [127:0]  memData [DEPTH];
  logic [4:0]    memCnt  [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [3:0]    bytePtr;
  logic          padErrQ;

  logic          clear, full, empty, sReady, push, pop;
  logic          outValid, outLast, mHs;
  logic [127:0]  headData;
  logic [4:0]    headCnt;
  logic [7:0]    headByte;
  logic [7:0]    padVal;
  logic          padOk;
  logic [4:0]    inCnt;
  logic          inBad;

  assign clear = Rst || !En;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Readiness looks only at registered occupancy, so a full FIFO refuses a
  // block even in a cycle that pops.
  assign sReady        = !clear && !full;
  assign s_axis.tready = sReady;
  assign push          = s_axis.tvalid && sReady;

  // Valid byte count for the incoming block.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    inCnt  = 5'd16;
    inBad  = 1'b0;
    padVal = s_axis.tdata[7:0];
    padOk  = (padVal >= 8'd1) && (padVal <= 8'd16);
    if (PadStrip && s_axis.tuser[0]) begin
      for (int k = 0; k < 16; k++) begin
        if (padOk && (k >= 16 - int'(padVal)) && (s_axis.tdata[127-8*k -: 8] != padVal))
          padOk = 1'b0;
      end
      if (padOk) inCnt = 5'd16 - padVal[4:0];
      else       inBad = 1'b1;
    end
  end

  assign headData = memData[rdPtr];
  assign headCnt  = memCnt[rdPtr];
  // Byte k sits at bits 127-8k; shifting right by 8*(15-k) brings it to [7:0].
  assign headByte = 8'(headData >> {~bytePtr, 3'b000});

  assign outValid = !clear && !empty && (headCnt != 5'd0);
  assign outLast  = ({1'b0, bytePtr} == headCnt - 5'd1);
  assign mHs      = outValid && m_axis.tready;
  // A zero-count (all padding) head entry is dropped without emitting anything.
  assign pop      = (mHs && outLast) || (!clear && !empty && (headCnt == 5'd0));

  assign m_axis.tvalid = outValid;
  assign m_axis.tdata  = outValid ? headByte : 8'h00;
  assign m_axis.tlast  = outValid && outLast;
  assign m_axis.tkeep  = '1;
  assign m_axis.tstrb  = '1;
  assign m_axis.tid    = '0;
  assign m_axis.tdest  = '0;
  assign m_axis.tuser  = '0;
  assign PadErr        = padErrQ;

  logic unusedSink;
  assign unusedSink = ^{s_axis.tkeep, s_axis.tstrb, s_axis.tlast, s_axis.tid, s_axis.tdest, 1'b0};

  // NOTE: storage is not reset; the pointers and count say which entries are live, so flushing them is enough.
  always_ff @(posedge Clk) begin
    if (push) begin
      memData[wrPtr] <= s_axis.tdata;
      memCnt[wrPtr]  <= inCnt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (clear) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      bytePtr <= '0;
      padErrQ <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (mHs)  bytePtr <= outLast ? 4'd0 : bytePtr + 4'd1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      padErrQ <= push && inBad;
    end
  end
endmodule

// File: tb/tb_aes_block_serializer.sv
module tb_aes_block_serializer;
  localparam int DEPTH = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic En  = 1'b1;
  logic PadStrip = 1'b0;
  logic PadErr;

  taxi_axis_if #(.DATA_W(128)) sIf ();
  taxi_axis_if #(.DATA_W(8))   mIf ();

  aes_block_serializer #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .PadStrip(PadStrip), .PadErr(PadErr),
    .s_axis(sIf), .m_axis(mIf)
  );

  always #5 Clk = ~Clk;

  logic mReadyDir = 1'b0;
  logic randReady = 1'b0;
  logic randMode  = 1'b0;
  assign mIf.tready = randMode ? randReady : mReadyDir;

  assign sIf.tkeep = '1;
  assign sIf.tstrb = '1;
  assign sIf.tlast = 1'b1;
  assign sIf.tid   = '0;
  assign sIf.tdest = '0;

  int passCnt = 0;
  int checkCnt = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Output collector and stall-stability monitor, both at the falling edge.
  logic [7:0] gotData[$];
  logic       gotLast[$];
  int         gotCyc[$];
  logic [7:0] expData[$];
  logic       expLast[$];
  logic       stabEn = 1'b0;
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic       prevLast = 1'b0;

  always @(posedge Clk) begin
    cyc++;
    #1 randReady = 1'($urandom_range(0, 1));
  end

  always @(negedge Clk) begin
    if (stabEn && prevStall) begin
      check("stall_tvalid", 128'(mIf.tvalid), 128'(1));
      check("stall_tdata", 128'(mIf.tdata), 128'(prevData));
      check("stall_tlast", 128'(mIf.tlast), 128'(prevLast));
    end
    prevStall = mIf.tvalid && !mIf.tready;
    prevData  = mIf.tdata;
    prevLast  = mIf.tlast;
    if (mIf.tvalid && mIf.tready) begin
      gotData.push_back(mIf.tdata);
      gotLast.push_back(mIf.tlast);
      gotCyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clearQueues();
    gotData.delete(); gotLast.delete(); gotCyc.delete();
    expData.delete(); expLast.delete();
  endtask

  task automatic addBlock(input logic [127:0] data, input int n);
    for (int k = 0; k < n; k++) begin
      expData.push_back(data[127-8*k -: 8]);
      expLast.push_back(k == n - 1);
    end
  endtask

  // Offers one block and returns after the accepting edge (+1).
  task automatic sendBlock(input string tag, input logic [127:0] data, input logic last,
                           input logic strip, input int budget);
    int n;
    sIf.tdata  = data;
    sIf.tuser  = last;
    PadStrip   = strip;
    sIf.tvalid = 1'b1;
    n = 0;
    while (!sIf.tready && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_accept"}, 128'(sIf.tready), 128'(1));
    tick();
    sIf.tvalid = 1'b0;
  endtask

  task automatic waitBytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (gotData.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_count"}, 128'(gotData.size()), 128'(n));
  endtask

  task automatic checkStream(input string tag);
    check({tag, "_len"}, 128'(gotData.size()), 128'(expData.size()));
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 128'(gotData[i]), 128'(expData[i]));
      check($sformatf("%s_last%0d", tag, i), 128'(gotLast[i]), 128'(expLast[i]));
    end
  endtask

  localparam logic [127:0] BLK_A   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_P4  = 128'h00112233_44556677_8899AABB_04040404;
  localparam logic [127:0] BLK_P16 = {16{8'h10}};
  localparam logic [127:0] BLK_BAD = 128'h00112233_44556677_8899AABB_CC030503;
  localparam logic [127:0] BLK_Z0  = 128'h00112233_44556677_8899AABB_CCDDEE00;
  localparam logic [127:0] BLK_P1  = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E01;
  localparam logic [127:0] BLK_B   = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] BLK_C   = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;

  initial begin
    sIf.tdata = '0; sIf.tuser = '0; sIf.tvalid = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_s_tready", 128'(sIf.tready), 128'(0));
    check("rst_m_tvalid", 128'(mIf.tvalid), 128'(0));
    check("rst_m_tlast", 128'(mIf.tlast), 128'(0));
    check("rst_m_tdata", 128'(mIf.tdata), 128'(0));
    check("rst_paderr", 128'(PadErr), 128'(0));
    Rst = 1'b0;
    #1;
    check("rel_s_tready", 128'(sIf.tready), 128'(1));

    // Single block, no stripping, byte 0 one cycle after accept
    mReadyDir = 1'b1;
    clearQueues();
    sendBlock("a", BLK_A, 1'b1, 1'b0, 50);
    check("a_lat_tvalid", 128'(mIf.tvalid), 128'(1));
    check("a_lat_tdata", 128'(mIf.tdata), 128'(8'h00));
    check("a_paderr", 128'(PadErr), 128'(0));
    waitBytes("a", 16, 100);
    addBlock(BLK_A, 16);
    checkStream("a");
    if (gotCyc.size() == 16) check("a_consec", 128'(gotCyc[15] - gotCyc[0]), 128'(15));

    // Valid 4-byte padding, then the same block not marked last
    clearQueues();
    sendBlock("p4", BLK_P4, 1'b1, 1'b1, 50);
    check("p4_paderr", 128'(PadErr), 128'(0));
    waitBytes("p4", 12, 100);
    repeat (5) tick();
    addBlock(BLK_P4, 12);
    checkStream("p4");
    clearQueues();
    sendBlock("p4nl", BLK_P4, 1'b0, 1'b1, 50);
    waitBytes("p4nl", 16, 100);
    addBlock(BLK_P4, 16);
    checkStream("p4nl");

    // Single-byte padding boundary
    clearQueues();
    sendBlock("p1", BLK_P1, 1'b1, 1'b1, 50);
    waitBytes("p1", 15, 100);
    repeat (3) tick();
    addBlock(BLK_P1, 15);
    checkStream("p1");

    // All-padding block is dropped with no output
    clearQueues();
    sendBlock("p16", BLK_P16, 1'b1, 1'b1, 50);
    check("p16_tvalid", 128'(mIf.tvalid), 128'(0));
    check("p16_paderr", 128'(PadErr), 128'(0));
    repeat (5) tick();
    check("p16_nobytes", 128'(gotData.size()), 128'(0));
    check("p16_empty_tvalid", 128'(mIf.tvalid), 128'(0));

    // Inconsistent padding bytes: pass through, one PadErr pulse
    sendBlock("bad", BLK_BAD, 1'b1, 1'b1, 50);
    check("bad_paderr_hi", 128'(PadErr), 128'(1));
    tick();
    check("bad_paderr_lo", 128'(PadErr), 128'(0));
    waitBytes("bad", 16, 100);
    addBlock(BLK_BAD, 16);
    checkStream("bad");

    // Padding value 0 is invalid
    clearQueues();
    sendBlock("z0", BLK_Z0, 1'b1, 1'b1, 50);
    check("z0_paderr_hi", 128'(PadErr), 128'(1));
    tick();
    check("z0_paderr_lo", 128'(PadErr), 128'(0));
    waitBytes("z0", 16, 100);
    addBlock(BLK_Z0, 16);
    checkStream("z0");

    // Fill under backpressure, then drain across pointer wrap with no gaps
    clearQueues();
    mReadyDir = 1'b0;
    stabEn = 1'b1;
    sendBlock("f1", BLK_A, 1'b0, 1'b0, 50);
    sendBlock("f2", BLK_B, 1'b0, 1'b0, 50);
    sIf.tdata = BLK_C; sIf.tuser = 1'b0; sIf.tvalid = 1'b1;
    #1;
    check("full_tready0", 128'(sIf.tready), 128'(0));
    repeat (3) tick();
    check("full_tready3", 128'(sIf.tready), 128'(0));
    check("full_head_tdata", 128'(mIf.tdata), 128'(8'h00));
    mReadyDir = 1'b1;
    begin
      int k;
      k = 0;
      while (!sIf.tready && k < 100) begin
        tick();
        k++;
      end
      check("refill_wait", 128'(k), 128'(16));
    end
    tick();
    sIf.tvalid = 1'b0;
    waitBytes("drain", 48, 200);
    addBlock(BLK_A, 16); addBlock(BLK_B, 16); addBlock(BLK_C, 16);
    checkStream("drain");
    if (gotCyc.size() == 48) check("drain_consec", 128'(gotCyc[47] - gotCyc[0]), 128'(47));

    // Random backpressure
    clearQueues();
    randMode = 1'b1;
    sendBlock("r1", BLK_C, 1'b0, 1'b0, 400);
    sendBlock("r2", BLK_P4, 1'b1, 1'b1, 400);
    sendBlock("r3", BLK_B, 1'b0, 1'b0, 400);
    sendBlock("r4", BLK_A, 1'b0, 1'b0, 400);
    waitBytes("rand", 60, 1000);
    addBlock(BLK_C, 16); addBlock(BLK_P4, 12); addBlock(BLK_B, 16); addBlock(BLK_A, 16);
    checkStream("rand");
    stabEn = 1'b0;
    randMode = 1'b0;
    mReadyDir = 1'b1;

    // Rst mid-block: remainder of block 2 is discarded
    clearQueues();
    sendBlock("x1", BLK_A, 1'b0, 1'b0, 50);
    sendBlock("x2", BLK_B, 1'b0, 1'b0, 50);
    waitBytes("x", 21, 100);
    Rst = 1'b1;
    #1;
    check("xr_s_tready", 128'(sIf.tready), 128'(0));
    check("xr_m_tvalid", 128'(mIf.tvalid), 128'(0));
    tick();
    Rst = 1'b0;
    #1;
    check("xr_rel_tready", 128'(sIf.tready), 128'(1));
    check("xr_rel_tvalid", 128'(mIf.tvalid), 128'(0));
    repeat (20) tick();
    check("xr_no_more", 128'(gotData.size()), 128'(21));
    clearQueues();
    sendBlock("xz", BLK_C, 1'b0, 1'b0, 50);
    check("xz_first", 128'(mIf.tdata), 128'(8'hDE));
    waitBytes("xz", 16, 100);
    addBlock(BLK_C, 16);
    checkStream("xz");

    // En=0 mid-block behaves the same way
    clearQueues();
    sendBlock("e1", BLK_C, 1'b0, 1'b0, 50);
    sendBlock("e2", BLK_B, 1'b0, 1'b0, 50);
    waitBytes("e", 21, 100);
    En = 1'b0;
    #1;
    check("en_s_tready", 128'(sIf.tready), 128'(0));
    check("en_m_tvalid", 128'(mIf.tvalid), 128'(0));
    tick();
    En = 1'b1;
    #1;
    check("en_rel_tready", 128'(sIf.tready), 128'(1));
    repeat (20) tick();
    check("en_no_more", 128'(gotData.size()), 128'(21));
    clearQueues();
    sendBlock("ez", BLK_A, 1'b0, 1'b0, 50);
    check("ez_first", 128'(mIf.tdata), 128'(8'h00));
    waitBytes("ez", 16, 100);
    addBlock(BLK_A, 16);
    checkStream("ez");

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
